// File: rtl/urng_pair_fifo_if.sv
// rtl/urng_pair_fifo_if.sv - uniform word input stream and u0/u1 pair output stream of urng_pair_fifo
interface urng_pair_fifo_if;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [47:0] u0;
  logic [15:0] u1;

  // Producer of words and consumer of pairs (generator + Box-Muller side).
  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  u0,
    input  u1
  );

  // The pairing FIFO itself.
  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output u0,
    output u1
  );
endinterface

// File: rtl/urng_pair_fifo.sv
// rtl/urng_pair_fifo.sv - packs 32-bit uniform word pairs into u0/u1 Box-Muller operands behind a small FIFO
// Optional macro U0_ZERO_GUARD_EN: replace an all-zero u0 with 48'h1 at push.
module urng_pair_fifo #(
  parameter int DEPTH  = 4,
  parameter int AW     = 2,
  parameter int DROP_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  urng_pair_fifo_if.slave   bus,
  output logic [AW:0]       level,
  output logic [DROP_W-1:0] drop_cnt
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HALF  = 1'b1
  } state_t;

  localparam logic [AW:0] LEVEL_FULL = (AW+1)'(DEPTH);

  state_t              state_q, state_d;
  logic [31:0]         hold_q, hold_d;
  logic [AW-1:0]       wptr_q, wptr_d;
  logic [AW-1:0]       rptr_q, rptr_d;
  logic [AW:0]         level_q, level_d;
  logic [DROP_W-1:0]   drop_q, drop_d;
  logic [63:0]         mem_q [DEPTH];

  logic                half;
  logic                full;
  logic                in_ready;
  logic                out_valid;
  logic                accept;
  logic                pop;
  logic                push;
  logic                drop;
  logic [47:0]         packed_u0;
  logic [47:0]         store_u0;
  logic [63:0]         entry;

  assign half      = (state_q == ST_HALF);
  assign full      = (level_q == LEVEL_FULL);
  assign out_valid = (level_q != '0);

  // Completing a pair into a full FIFO is only safe when the head leaves this cycle.
  assign in_ready  = !half || !full || bus.out_ready;

  assign accept    = bus.in_valid && in_ready && !flush;
  assign pop       = out_valid && bus.out_ready && !flush;
  assign push      = accept && half;
  assign drop      = bus.in_valid && !in_ready && !flush;

  assign packed_u0 = {hold_q, bus.in_data[31:16]};

`ifdef U0_ZERO_GUARD_EN
  // The downstream -ln(u0) stage must never see zero.
  assign store_u0  = (packed_u0 == 48'h0) ? 48'h1 : packed_u0;
`else
  assign store_u0  = packed_u0;
`endif

  assign entry     = {store_u0, bus.in_data[15:0]};

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else if (accept) begin
      case (state_q)
        ST_EMPTY: begin
          hold_d  = bus.in_data;
          state_d = ST_HALF;
        end
        ST_HALF: begin
          state_d = ST_EMPTY;
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    drop_d  = drop_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end else begin
      if (push) begin
        wptr_d = wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_d = rptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
      if (drop && (drop_q != '1)) begin
        drop_d = drop_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_EMPTY;
      hold_q  <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      drop_q  <= drop_d;
    end
  end

  // Flush leaves the array untouched; only the pointers forget it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push && !flush) begin
      mem_q[wptr_q] <= entry;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.u0        = mem_q[rptr_q][63:16];
  assign bus.u1        = mem_q[rptr_q][15:0];
  assign level         = level_q;
  assign drop_cnt      = drop_q;

endmodule
